// File: rtl/tinuc_hazard_pkg.sv
// rtl/tinuc_hazard_pkg.sv - shared types and constants for the TinuC hazard controller
// Purpose: forwarding-select and controller-state encodings plus the x0 register index.
package tinuc_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN,
    HZ_HOLD
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - EX-stage operand forwarding select for one ALU operand
// Purpose: picks the youngest in-flight producer of rs; MEM is younger than WB so it wins.
// Ports:
//   rs            in  5  source register of the EX instruction
//   mem_rd        in  5  destination register in MEM
//   mem_reg_write in  1  MEM instruction writes the register file
//   wb_rd         in  5  destination register in WB
//   wb_reg_write  in  1  WB instruction writes the register file
//   sel           out 2  FWD_RF / FWD_MEM / FWD_WB
module fwd_select
  import tinuc_hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output fwd_sel_t   sel
);

  // x0 is hardwired to zero, so a write to it is never a forwarding source.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && mem_rd != REG_ZERO && mem_rd == rs) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && wb_rd != REG_ZERO && wb_rd == rs) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard controller for the 5-stage TinuC pipeline
// Purpose: PC/IF-ID enables, IF-ID/ID-EX/EX-MEM clears and EX forwarding selects.
//   One bubble on load-use, three-bank flush on a taken branch (resolved in MEM),
//   full freeze on mem_hold with any branch seen during the hold deferred until release.
//   Optional performance counters when HAZARD_PERF_EN is defined.
// Ports:
//   CLK, RESET                 clock (rising) and asynchronous active-high reset
//   id_rs1/2, id_use_rs1/2     ID-stage source registers and their use flags
//   ex_rs1/2, ex_rd            EX-stage sources and destination
//   ex_mem_read                EX instruction is a load
//   mem_rd, mem_reg_write      MEM-stage destination and write flag
//   mem_br_taken               taken branch resolved in MEM
//   wb_rd, wb_reg_write        WB-stage destination and write flag
//   mem_hold                   data memory not ready
//   pc_en, ifid_en, bank_en    stage enables
//   ifid_clr, idex_clr, exmem_clr  synchronous bank clears
//   fwd_a, fwd_b               ALU operand selects
//   stall_cnt, flush_cnt       load-use bubble / flush counters (zero unless HAZARD_PERF_EN)
module pipeline_hazard_ctrl
  import tinuc_hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_br_taken,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_hold,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             bank_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state;
  logic      flush_pend;
  logic      load_use;
  logic      flush;
  logic      apply_flush;
  logic      apply_bubble;
  fwd_sel_t  sel_a;
  fwd_sel_t  sel_b;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  assign flush    = mem_br_taken || flush_pend;

  // A hold masks everything; a flush squashes the load-use victim, so no bubble then.
  assign apply_flush  = !mem_hold && flush;
  assign apply_bubble = !mem_hold && !flush && load_use;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    bank_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    if (RESET) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      bank_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (mem_hold) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      bank_en = 1'b0;
    end else if (flush) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  fwd_select u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  fwd_select u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );

  assign fwd_a = RESET ? FWD_RF : sel_a;
  assign fwd_b = RESET ? FWD_RF : sel_b;

  // The release cycle of a hold runs under RUN rules, so a deferred flush fires right away.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= HZ_RUN;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (mem_hold) begin
            state      <= HZ_HOLD;
            flush_pend <= flush_pend | mem_br_taken;
          end else if (flush) begin
            flush_pend <= 1'b0;
          end
        end
        HZ_HOLD: begin
          if (mem_hold) begin
            flush_pend <= flush_pend | mem_br_taken;
          end else begin
            state <= HZ_RUN;
            if (flush) begin
              flush_pend <= 1'b0;
            end
          end
        end
        default: begin
          state      <= HZ_RUN;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (apply_bubble) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (apply_flush) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  logic unused_perf;
  assign unused_perf = apply_bubble ^ apply_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write;
  logic             mem_br_taken, wb_reg_write, mem_hold;
  logic             pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, bank_en;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_br_taken  (mem_br_taken),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_hold      (mem_hold),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_clr      (ifid_clr),
    .idex_clr      (idex_clr),
    .exmem_clr     (exmem_clr),
    .bank_en       (bank_en),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit          m_pend  = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_load_use();
    bit hit;
    hit = 1'b0;
    if (ex_mem_read && ex_rd != 0) begin
      if (id_use_rs1 && id_rs1 == ex_rd) hit = 1'b1;
      if (id_use_rs2 && id_rs2 == ex_rd) hit = 1'b1;
    end
    return hit;
  endfunction

  // producers listed youngest first; first live match wins
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    logic [4:0] rd_l[2];
    logic       we_l[2];
    logic [1:0] code_l[2];
    rd_l[0] = mem_rd; we_l[0] = mem_reg_write; code_l[0] = 2'b10;
    rd_l[1] = wb_rd;  we_l[1] = wb_reg_write;  code_l[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      if (we_l[i] && rd_l[i] != 0 && rd_l[i] == rs) return code_l[i];
    end
    return 2'b00;
  endfunction

  task automatic check_all();
    logic [5:0] e;  // {pc_en, ifid_en, bank_en, ifid_clr, idex_clr, exmem_clr}
    bit         fl;
    fl = mem_br_taken || m_pend;
    if (RESET)                e = 6'b000_111;
    else if (mem_hold)        e = 6'b000_000;
    else if (fl)              e = 6'b111_111;
    else if (ref_load_use())  e = 6'b001_010;
    else                      e = 6'b111_000;
    chk("pc_en",     {31'd0, pc_en},     {31'd0, e[5]});
    chk("ifid_en",   {31'd0, ifid_en},   {31'd0, e[4]});
    chk("bank_en",   {31'd0, bank_en},   {31'd0, e[3]});
    chk("ifid_clr",  {31'd0, ifid_clr},  {31'd0, e[2]});
    chk("idex_clr",  {31'd0, idex_clr},  {31'd0, e[1]});
    chk("exmem_clr", {31'd0, exmem_clr}, {31'd0, e[0]});
    chk("fwd_a", {30'd0, fwd_a}, RESET ? 32'd0 : {30'd0, ref_fwd(ex_rs1)});
    chk("fwd_b", {30'd0, fwd_b}, RESET ? 32'd0 : {30'd0, ref_fwd(ex_rs2)});
    chk("stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
    chk("flush_cnt", flush_cnt, PERF ? m_flush : 32'd0);
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_next();
    if (RESET) begin
      model_reset();
    end else if (mem_hold) begin
      m_pend = m_pend | mem_br_taken;
    end else if (mem_br_taken || m_pend) begin
      m_pend  = 1'b0;
      m_flush = m_flush + 1;
    end else if (ref_load_use()) begin
      m_stall = m_stall + 1;
    end
  endtask

  // called at a negedge with inputs already driven
  task automatic step();
    #2;
    check_all();
    model_next();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; mem_br_taken = 0;
    wb_rd = 0; wb_reg_write = 0; mem_hold = 0;
  endtask

  initial begin
    RESET = 1'b1;
    set_idle();
    @(negedge CLK);
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_exmem_clr", {31'd0, exmem_clr}, 32'd1);
    step();
    RESET = 1'b0;
    step();

    // lw x5,0(x1); add x6,x5,x2
    set_idle();
    ex_mem_read = 1; ex_rd = 5;
    id_rs1 = 5; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_idex_clr", {31'd0, idex_clr}, 32'd1);
    step();
    set_idle();
    id_rs1 = 5; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
    mem_rd = 5; mem_reg_write = 1;
    step();
    set_idle();
    ex_rs1 = 5; ex_rs2 = 2; wb_rd = 5; wb_reg_write = 1;
    #1;
    chk("lu_fwd_a_wb", {30'd0, fwd_a}, 32'd1);
    if (PERF) chk("lu_stall_cnt", stall_cnt, 32'd1);
    step();

    // add x3,x1,x2; sub x4,x3,x3 with x3 also in WB
    set_idle();
    ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
    #1;
    chk("mem_beats_wb_a", {30'd0, fwd_a}, 32'd2);
    chk("mem_beats_wb_b", {30'd0, fwd_b}, 32'd2);
    step();

    // branch taken together with a load-use
    set_idle();
    mem_br_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    #1;
    chk("br_lu_pc_en", {31'd0, pc_en}, 32'd1);
    chk("br_lu_ifid_clr", {31'd0, ifid_clr}, 32'd1);
    step();

    // hold three cycles with a branch in the second
    set_idle();
    mem_hold = 1;
    step();
    mem_br_taken = 1;
    step();
    mem_br_taken = 0;
    step();
    mem_hold = 0;
    #1;
    chk("hold_release_exmem_clr", {31'd0, exmem_clr}, 32'd1);
    step();
    step();

    // x0 is never a source
    set_idle();
    ex_rs1 = 0; mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
    #1;
    chk("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    step();
    set_idle();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk("x0_no_stall", {31'd0, pc_en}, 32'd1);
    step();

    // reset asserted during hold with a pending flush, pulse not spanning an edge
    set_idle();
    mem_hold = 1; mem_br_taken = 1;
    step();
    mem_br_taken = 0;
    RESET = 1'b1;
    #1;
    chk("async_rst_clr", {31'd0, ifid_clr}, 32'd1);
    RESET = 1'b0;
    model_reset();
    mem_hold = 0;
    #1;
    chk("rst_no_pend_flush", {31'd0, ifid_clr}, 32'd0);
    step();

    // randomized traffic with small register range for frequent collisions
    for (int n = 0; n < 3000; n++) begin
      RESET         = ($urandom_range(0, 149) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_rs1        = 5'($urandom_range(0, 3));
      ex_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_br_taken  = ($urandom_range(0, 5) == 0);
      wb_rd         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      mem_hold      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
